// File: rtl/regfile_decode_stage.sv
// regfile_decode_stage
//
// Decode-side register file plus the Decode/Execute pipeline register.
// The 32x32 architectural register file takes writes from the writeback bus.
// Two source operands are read combinationally, with a same-cycle
// write-to-read bypass. Operands, register indices, PC values and the valid
// bit are then registered into the Execute stage.
//
// Ports:
//   clk, rst                   rising-edge clock, async active-low reset
//   RegWrite_W, RD_W, Result_W writeback bus (enable, destination, data)
//   Instr_D                    Decode instruction; rs1=[19:15] rs2=[24:20] rd=[11:7]
//   PC_D, PCPlus4_D, Valid_D   Decode PC values and slot-valid flag
//   Stall_E, Flush_E           hazard-unit controls for the D/E register
//   RD1_E, RD2_E               registered source operands
//   Rs1_E, Rs2_E, Rd_E         registered register indices
//   PC_E, PCPlus4_E, Valid_E   registered PC values and slot-valid flag
//
// Pipeline control contract:
//   Flush_E inserts a bubble: every E output becomes 0, including Valid_E.
//   Otherwise Stall_E freezes every E output.
//   Otherwise the D/E register captures the Decode slot.
//   Flush_E wins when Flush_E and Stall_E are both high.
//   Writeback writes are never gated by Stall_E or Flush_E.
module regfile_decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWrite_W,
  input  logic [$clog2(NREGS)-1:0] RD_W,
  input  logic [XLEN-1:0]          Result_W,
  input  logic [31:0]              Instr_D,
  input  logic [XLEN-1:0]          PC_D,
  input  logic [XLEN-1:0]          PCPlus4_D,
  input  logic                     Valid_D,
  input  logic                     Stall_E,
  input  logic                     Flush_E,
  output logic [XLEN-1:0]          RD1_E,
  output logic [XLEN-1:0]          RD2_E,
  output logic [$clog2(NREGS)-1:0] Rs1_E,
  output logic [$clog2(NREGS)-1:0] Rs2_E,
  output logic [$clog2(NREGS)-1:0] Rd_E,
  output logic [XLEN-1:0]          PC_E,
  output logic [XLEN-1:0]          PCPlus4_E,
  output logic                     Valid_E
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rd1, rd2;
  logic            wr_en;

  assign rs1   = Instr_D[15 +: AW];
  assign rs2   = Instr_D[20 +: AW];
  assign rd    = Instr_D[7 +: AW];
  assign wr_en = RegWrite_W && (RD_W != '0);

  // regs[0] is reset and never written. Reads of x0 are forced to 0 below,
  // so that entry is never observed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[RD_W] <= Result_W;
    end
  end

  // Bypass uses wr_en rather than RegWrite_W. A write aimed at x0 therefore
  // never leaks into a read of x0.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) begin
      rd1 = (wr_en && (RD_W == rs1)) ? Result_W : regs[rs1];
    end
    if (rs2 != '0) begin
      rd2 = (wr_en && (RD_W == rs2)) ? Result_W : regs[rs2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RD1_E     <= '0;
      RD2_E     <= '0;
      Rs1_E     <= '0;
      Rs2_E     <= '0;
      Rd_E      <= '0;
      PC_E      <= '0;
      PCPlus4_E <= '0;
      Valid_E   <= 1'b0;
    end else if (Flush_E) begin
      RD1_E     <= '0;
      RD2_E     <= '0;
      Rs1_E     <= '0;
      Rs2_E     <= '0;
      Rd_E      <= '0;
      PC_E      <= '0;
      PCPlus4_E <= '0;
      Valid_E   <= 1'b0;
    end else if (!Stall_E) begin
      RD1_E     <= rd1;
      RD2_E     <= rd2;
      Rs1_E     <= rs1;
      Rs2_E     <= rs2;
      Rd_E      <= rd;
      PC_E      <= PC_D;
      PCPlus4_E <= PCPlus4_D;
      Valid_E   <= Valid_D;
    end
  end

endmodule

// File: doc/regfile_decode_stage.md
# regfile_decode_stage

Decode-side consumer of the writeback bus. The block holds the 32×32 architectural register file and accepts the writeback result (`RegWrite_W`, `RD_W`, `Result_W`). It reads the two source operands of the instruction in Decode, with same-cycle write-to-read bypass, and registers operands, register indices and PC values into the Decode/Execute pipeline register. Stall and flush controls come from the hazard unit.

## Interface
Parameters:
- `XLEN`, 32, data width of registers, PC and result bus
- `NREGS`, 32, number of architectural registers; index width is log2(NREGS) = 5

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `RegWrite_W`  in  1  writeback enable
- `RD_W`  in  5  writeback destination index
- `Result_W`  in  XLEN  writeback data
- `Instr_D`  in  32  instruction in Decode; rs1=[19:15], rs2=[24:20], rd=[11:7]
- `PC_D`  in  XLEN  PC of Decode instruction
- `PCPlus4_D`  in  XLEN  PC+4 of Decode instruction
- `Valid_D`  in  1  Decode slot holds a real instruction
- `Stall_E`  in  1  hold D/E register contents
- `Flush_E`  in  1  insert bubble into D/E register
- `RD1_E`, `RD2_E`  out  XLEN  registered source operands
- `Rs1_E`, `Rs2_E`, `Rd_E`  out  5  registered register indices, for forwarding and hazard logic
- `PC_E`, `PCPlus4_E`  out  XLEN  registered PC values
- `Valid_E`  out  1  Execute slot holds a real instruction

## Operation
- Register file:
  - x0 always reads 0; writes to x0 are discarded.
  - Write occurs on rising `clk` when `RegWrite_W`=1 and `RD_W`≠0.
  - Writes are never blocked by `Stall_E` or `Flush_E`.
- Read, combinational:
  - RD1 = 0 if rs1=0.
  - Otherwise RD1 = `Result_W` if `RegWrite_W`=1 and `RD_W`=rs1 (bypass).
  - Otherwise RD1 = regs[rs1].
  - RD2 is computed the same way from rs2.
- D/E register update on each rising `clk`, in priority order:
  1. `Flush_E`=1: all E outputs ← 0, including `Valid_E`.
  2. Else `Stall_E`=1: all E outputs hold.
  3. Else E outputs ← {RD1, RD2, rs1, rs2, rd, `PC_D`, `PCPlus4_D`, `Valid_D`}.
- `Flush_E` overrides `Stall_E` when both are asserted.
- No arithmetic is performed. All widths pass through unmodified.

## Timing
- Reset (`rst`=0, asynchronous): all 31 writable registers ← 0 and all E outputs ← 0. Takes effect immediately, independent of `clk`.
  - Reset deassertion is synchronous to `clk` externally. The first capture happens on the first rising edge with `rst`=1.
  - Reset asserted mid-operation discards any in-flight write and clears all state.
- Latency:
  - Register write is visible to a Decode read in the same cycle via the bypass, and from the register array on the following cycle.
  - Decode → E outputs: 1 cycle.
- Simultaneous write and read of the same index in one cycle: the read returns the new `Result_W`, never the stale value.
- Both rs1 and rs2 equal to `RD_W`: both reads are bypassed.
- `RD_W`=0 with `RegWrite_W`=1: no write and no bypass; reads of x0 still return 0.
- Stall held for N cycles: E outputs stay constant for N cycles. Writebacks during the stall still update the array. Held `RD1_E`/`RD2_E` are not refreshed; Execute forwarding handles that case.

## Test plan
- Reset: drive `rst`=0 mid-cycle with E outputs nonzero → all E outputs read 0 immediately. After release, reading x5 → `RD1_E`=0.
- Write then read: `RegWrite_W`=1, `RD_W`=5, `Result_W`=0xDEADBEEF in cycle 0. Instr with rs1=5 in cycle 1 → `RD1_E`=0xDEADBEEF after the cycle-1 edge.
- Bypass: same cycle `RD_W`=7, `Result_W`=0x12345678, Instr rs1=7, rs2=7 → after the edge, `RD1_E`=`RD2_E`=0x12345678.
- x0: write `RD_W`=0, `Result_W`=0xFFFFFFFF, then read rs1=0 → `RD1_E`=0, both in the same cycle and the next cycle.
- Stall/flush:
  - Capture `PC_D`=0x100, then `Stall_E`=1 for 2 cycles while `PC_D`=0x104 → `PC_E` stays 0x100.
  - Then `Stall_E`=`Flush_E`=1 → all E outputs 0, `Valid_E`=0.
- Write during stall: `Stall_E`=1, write x3=0x55. Release stall with rs1=3 → `RD1_E`=0x55.
